// File: rtl/battle_controller.sv
`default_nettype none
// ============================================================================
// Module   : battle_controller
// Purpose  : Two-player note battle sequencer. Optional per-round seconds
//            countdown is built when BATTLE_COUNTDOWN_EN is defined.
// Revision : 1.0
// ============================================================================
module battle_controller #(
   parameter int CLK_PER_SEC = 50000000,
   parameter int ROUND_SEC   = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       note_valid,
   input  logic       timer_done,
   output logic       battle_en,
   output logic       timer_restart,
   output logic       player,
   output logic [7:0] score1,
   output logic [7:0] score2,
   output logic [1:0] winner,
   output logic       done,
   output logic [2:0] state,
   output logic [5:0] seconds_left
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_ARM1   = 3'd1;
   localparam logic [2:0] c_P1     = 3'd2;
   localparam logic [2:0] c_ARM2   = 3'd3;
   localparam logic [2:0] c_P2     = 3'd4;
   localparam logic [2:0] c_RESULT = 3'd5;

   localparam logic [1:0] c_WIN_NONE = 2'b00;
   localparam logic [1:0] c_WIN_P1   = 2'b01;
   localparam logic [1:0] c_WIN_P2   = 2'b10;
   localparam logic [1:0] c_WIN_TIE  = 2'b11;

   if ((ROUND_SEC < 1) || (ROUND_SEC > 63) || (CLK_PER_SEC < 1)) begin : g_param_check
      $error("battle_controller: ROUND_SEC must be 1..63 and CLK_PER_SEC >= 1");
   end

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic       r_abort_pend;
   logic       w_abort_pend_nxt;
   logic       w_in_round;
   logic       w_in_battle;

   logic       r_battle_en;
   logic       r_player;
   logic       r_done;
   logic [7:0] r_score1;
   logic [7:0] r_score2;
   logic [1:0] r_winner;

   logic       w_battle_en_nxt;
   logic       w_player_nxt;
   logic       w_done_nxt;
   logic [7:0] w_score1_nxt;
   logic [7:0] w_score2_nxt;
   logic [1:0] w_winner_nxt;

   assign w_in_round  = (r_state == c_P1) || (r_state == c_P2);
   assign w_in_battle = (r_state == c_ARM1) || (r_state == c_P1) ||
                        (r_state == c_ARM2) || (r_state == c_P2);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= c_IDLE;
         r_abort_pend <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_abort_pend <= w_abort_pend_nxt;
      end
   end

   // Next-state logic; abort overrides every other input
   always_comb begin
      w_next           = r_state;
      w_abort_pend_nxt = 1'b0;
      if (abort) begin
         w_next           = c_IDLE;
         w_abort_pend_nxt = w_in_battle;
      end else begin
         case (r_state)
            c_IDLE:   if (start)      w_next = c_ARM1;
            c_ARM1:                   w_next = c_P1;
            c_P1:     if (timer_done) w_next = c_ARM2;
            c_ARM2:                   w_next = c_P2;
            c_P2:     if (timer_done) w_next = c_RESULT;
            c_RESULT: if (start)      w_next = c_ARM1;
            default:                  w_next = c_IDLE;
         endcase
      end
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      w_score1_nxt = r_score1;
      w_score2_nxt = r_score2;
      w_winner_nxt = r_winner;

      if (!abort && note_valid && (r_state == c_P1) && (r_score1 != 8'hFF))
         w_score1_nxt = r_score1 + 8'd1;
      if (!abort && note_valid && (r_state == c_P2) && (r_score2 != 8'hFF))
         w_score2_nxt = r_score2 + 8'd1;

      if (w_next == c_ARM1) begin
         w_score1_nxt = 8'd0;
         w_score2_nxt = 8'd0;
         w_winner_nxt = c_WIN_NONE;
      end else if ((r_state == c_P2) && (w_next == c_RESULT)) begin
         // Compare against the post-increment score so a final note counts
         if (r_score1 > w_score2_nxt)
            w_winner_nxt = c_WIN_P1;
         else if (w_score2_nxt > r_score1)
            w_winner_nxt = c_WIN_P2;
         else
            w_winner_nxt = c_WIN_TIE;
      end

      w_battle_en_nxt = (w_next == c_P1) || (w_next == c_P2);
      w_player_nxt    = (w_next == c_ARM2) || (w_next == c_P2);
      w_done_nxt      = (w_next == c_RESULT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_battle_en <= 1'b0;
         r_player    <= 1'b0;
         r_done      <= 1'b0;
         r_score1    <= 8'd0;
         r_score2    <= 8'd0;
         r_winner    <= c_WIN_NONE;
      end else begin
         r_battle_en <= w_battle_en_nxt;
         r_player    <= w_player_nxt;
         r_done      <= w_done_nxt;
         r_score1    <= w_score1_nxt;
         r_score2    <= w_score2_nxt;
         r_winner    <= w_winner_nxt;
      end
   end

   assign timer_restart = (r_state == c_ARM1) || (r_state == c_ARM2) || r_abort_pend;
   assign battle_en     = r_battle_en;
   assign player        = r_player;
   assign done          = r_done;
   assign score1        = r_score1;
   assign score2        = r_score2;
   assign winner        = r_winner;
   assign state         = r_state;

`ifdef BATTLE_COUNTDOWN_EN
   localparam int              c_PW        = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_PER_SEC - 1);
   localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);
   localparam logic [5:0]      c_ROUND     = 6'(ROUND_SEC);

   logic [c_PW-1:0] r_presc;
   logic [5:0]      r_secs;

   // Loads on the way into an arm state so the full count shows at round start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
         r_secs  <= 6'd0;
      end else if ((w_next == c_ARM1) || (w_next == c_ARM2)) begin
         r_presc <= '0;
         r_secs  <= c_ROUND;
      end else if (w_next == c_IDLE) begin
         r_presc <= '0;
         r_secs  <= 6'd0;
      end else if (w_in_round) begin
         if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            if (r_secs != 6'd0)
               r_secs <= r_secs - 6'd1;
         end else begin
            r_presc <= r_presc + c_PRESC_ONE;
         end
      end
   end

   assign seconds_left = r_secs;
`else
   assign seconds_left = 6'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_battle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_battle_controller
// Purpose  : Randomised and directed self-checking bench for battle_controller.
// Revision : 1.0
// ============================================================================
module tb_battle_controller;

   localparam int c_CPS = 10;
   localparam int c_RS  = 3;

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic       start      = 1'b0;
   logic       abort      = 1'b0;
   logic       note_valid = 1'b0;
   logic       timer_done = 1'b0;
   logic       battle_en;
   logic       timer_restart;
   logic       player;
   logic [7:0] score1;
   logic [7:0] score2;
   logic [1:0] winner;
   logic       done;
   logic [2:0] state;
   logic [5:0] seconds_left;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: phase (0..5), scores, winner, cycles elapsed in round
   int m_state, m_s1, m_s2, m_win, m_rcyc;
   bit m_abpend;

   always #5 clk = ~clk;

   battle_controller #(.CLK_PER_SEC(c_CPS), .ROUND_SEC(c_RS)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .note_valid   (note_valid),
      .timer_done   (timer_done),
      .battle_en    (battle_en),
      .timer_restart(timer_restart),
      .player       (player),
      .score1       (score1),
      .score2       (score2),
      .winner       (winner),
      .done         (done),
      .state        (state),
      .seconds_left (seconds_left)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_secs();
`ifdef BATTLE_COUNTDOWN_EN
      int s;
      if (m_state == 0) return 0;
      s = c_RS - m_rcyc / c_CPS;
      return (s < 0) ? 0 : s;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_state = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_rcyc = 0; m_abpend = 0;
   endtask

   task automatic model_step();
      int  ns;
      bit  playing;
      ns      = m_state;
      playing = (m_state == 2) || (m_state == 4);
      if (abort) ns = 0;
      else begin
         case (m_state)
            0: if (start) ns = 1;
            1: ns = 2;
            2: begin
               if (note_valid && m_s1 < 255) m_s1++;
               if (timer_done) ns = 3;
            end
            3: ns = 4;
            4: begin
               if (note_valid && m_s2 < 255) m_s2++;
               if (timer_done) begin
                  ns    = 5;
                  m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
               end
            end
            5: if (start) ns = 1;
            default: ns = 0;
         endcase
      end
      m_abpend = abort && (m_state >= 1) && (m_state <= 4);
      if (ns == 1) begin m_s1 = 0; m_s2 = 0; m_win = 0; end
      if (ns == 1 || ns == 3 || ns == 0) m_rcyc = 0;
      else if (playing) m_rcyc++;
      m_state = ns;
   endtask

   task automatic compare_all();
      check("state",         state,         m_state);
      check("battle_en",     battle_en,     (m_state == 2) || (m_state == 4));
      check("timer_restart", timer_restart, (m_state == 1) || (m_state == 3) || m_abpend);
      check("score1",        score1,        m_s1);
      check("score2",        score2,        m_s2);
      check("winner",        winner,        m_win);
      check("done",          done,          m_state == 5);
      check("seconds_left",  seconds_left,  exp_secs());
      if (m_state >= 1 && m_state <= 4)
         check("player", player, m_state >= 3);
   endtask

   // Called at a negedge: apply inputs, advance one clock, check at next negedge
   task automatic cyc(input bit st, input bit ab, input bit nv, input bit td);
      start = st; abort = ab; note_valid = nv; timer_done = td;
      @(posedge clk);
      if (reset) model_step(); else model_reset();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic notes(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
   endtask

   initial begin
      int sec_p1, sec_10, sec_30;
`ifdef BATTLE_COUNTDOWN_EN
      sec_p1 = 3; sec_10 = 2; sec_30 = 0;
`else
      sec_p1 = 0; sec_10 = 0; sec_30 = 0;
`endif
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      reset = 1'b1;
      idle(2);

      // Full battle: 5 vs 3 notes
      cyc(1, 0, 0, 0);
      check("arm1_restart", timer_restart, 1);
      cyc(0, 0, 0, 0);
      notes(5);
      cyc(0, 0, 0, 1);
      check("arm2_restart", timer_restart, 1);
      cyc(0, 0, 0, 0);
      notes(3);
      cyc(0, 0, 0, 1);
      check("A_score1", score1, 5);
      check("A_score2", score2, 3);
      check("A_winner", winner, 1);
      check("A_done",   done,   1);
      idle(2);

      // Tie
      cyc(1, 0, 0, 0); idle(1); notes(2); cyc(0, 0, 0, 1);
      idle(1); notes(2); cyc(0, 0, 0, 1);
      check("tie_winner", winner, 3);

      // Saturation
      cyc(1, 0, 0, 0); idle(1); notes(300);
      check("sat_score1", score1, 255);
      cyc(0, 0, 0, 1); idle(1); cyc(0, 0, 0, 1);
      check("sat_winner", winner, 1);

      // Note coincident with timer_done
      cyc(1, 0, 0, 0); idle(1); notes(6);
      cyc(0, 0, 1, 1);
      check("coinc_score1", score1, 7);
      check("coinc_state",  state,  3);

      // Abort in P2 with start held high
      cyc(0, 0, 0, 0); notes(2);
      cyc(1, 1, 0, 0);
      check("abort_state",   state,         0);
      check("abort_restart", timer_restart, 1);
      check("abort_s1",      score1,        7);
      check("abort_s2",      score2,        2);
      idle(1);
      check("abort_restart_clear", timer_restart, 0);

      // Countdown over a long P1
      cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
      check("secs_p1_entry", seconds_left, sec_p1);
      idle(10);
      check("secs_after10", seconds_left, sec_10);
      idle(20);
      check("secs_after30", seconds_left, sec_30);
      idle(5);
      check("secs_held", seconds_left, sec_30);

      // Asynchronous reset mid-P1 with score1=4
      cyc(0, 0, 0, 1); idle(1); cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0); idle(1); notes(4);
      check("pre_reset_s1", score1, 4);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("rst_state",     state,     0);
      check("rst_score1",    score1,    0);
      check("rst_battle_en", battle_en, 0);
      compare_all();
      cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
      reset = 1'b1;
      idle(3);
      check("post_reset_idle", state, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/battle_controller.md
BATTLE_CONTROLLER -- requirements
Module: battle_controller

Interface
REQ-001 Parameter CLK_PER_SEC, default 50000000, clock cycles per second (countdown prescaler).
REQ-002 Parameter ROUND_SEC, default 60, seconds per player round (countdown load value, 1..63).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a battle; sampled in IDLE and RESULT only.
REQ-006 abort  input  1  cancel the battle; return to IDLE from any state.
REQ-007 note_valid  input  1  one-cycle pulse per note played by the active player.
REQ-008 timer_done  input  1  level from the external round timer; high means the round time has elapsed.
REQ-009 battle_en  output  1  run enable for the external round timer.
REQ-010 timer_restart  output  1  one-cycle clear pulse for the external round timer.
REQ-011 player  output  1  active player: 0 = P1, 1 = P2.
REQ-012 score1, score2  output  8 each  note counts for P1 and P2.
REQ-013 winner  output  2  00 none, 01 P1, 10 P2, 11 tie.
REQ-014 done  output  1  high while in RESULT.
REQ-015 state  output  3  IDLE=0, ARM1=1, P1=2, ARM2=3, P2=4, RESULT=5.
REQ-016 seconds_left  output  6  remaining seconds of the current round.

Function
REQ-017 IDLE: battle_en=0; start=1 -> ARM1.
REQ-018 ARM1: lasts one cycle; timer_restart=1; score1 and score2 clear to 0; winner clears to 00; -> P1.
REQ-019 P1: battle_en=1, player=0; each note_valid increments score1; timer_done=1 -> ARM2.
REQ-020 ARM2: lasts one cycle; timer_restart=1, battle_en=0, player=1; -> P2.
REQ-021 P2: battle_en=1, player=1; each note_valid increments score2; timer_done=1 -> RESULT.
REQ-022 RESULT: battle_en=0, done=1; winner is registered on entry and holds; scores hold; start=1 -> ARM1.
REQ-023 winner: 01 if score1>score2, 10 if score2>score1, 11 if equal; the comparison includes any note counted on the transition cycle.
REQ-024 Scores saturate at 255; a further note_valid leaves the score unchanged.
REQ-025 note_valid is ignored in IDLE, ARM1, ARM2 and RESULT.
REQ-026 note_valid and timer_done high in the same P1/P2 cycle: the note is counted and the transition is taken.
REQ-027 timer_done is ignored outside P1/P2.
REQ-028 abort has priority over start, timer_done and note_valid; from ARM1, P1, ARM2 or P2 it forces IDLE with a one-cycle timer_restart=1 and retains the scores.
REQ-029 abort in IDLE or RESULT -> IDLE with no timer_restart pulse.
REQ-030 start while in ARM1, P1, ARM2 or P2 is ignored.
REQ-031 All outputs are registered, except timer_restart, which is a Moore decode of ARM1/ARM2 or an abort-pending flag.

Reset
REQ-032 reset=0 asynchronously forces: state=IDLE; battle_en=0; timer_restart=0; player=0; score1=0; score2=0; winner=00; done=0; seconds_left=0; prescaler=0.
REQ-033 Reset asserted during a round abandons it; after release the block sits in IDLE until start.

Configuration
REQ-034 Macro BATTLE_COUNTDOWN_EN defined:
  - ARM1/ARM2 load seconds_left=ROUND_SEC and clear the prescaler.
  - In P1/P2, seconds_left decrements by 1 every CLK_PER_SEC cycles, saturating at 0.
  - seconds_left holds in RESULT and clears to 0 in IDLE.
REQ-035 Macro not defined: no prescaler is built and seconds_left is constant 0.

Verification
REQ-036 Bench parameters: CLK_PER_SEC=10, ROUND_SEC=3.
  - Reset low mid-P1 with score1=4 -> state=0, score1=0, battle_en=0 immediately.
  - start, 5 notes in P1, timer_done, 3 notes in P2, timer_done -> timer_restart pulses on state=1 and on state=3; RESULT: score1=5, score2=3, winner=01, done=1.
  - 2 notes per player -> winner=11; 300 notes in P1 -> score1=255.
  - note_valid and timer_done in the same P1 cycle with score1=6 -> score1=7, state=3 next.
  - abort in P2 with start held high -> state=0, one timer_restart pulse, scores retained.
  - BATTLE_COUNTDOWN_EN defined -> seconds_left=3 at P1 entry, 2 after 10 cycles, 0 after 30 cycles and held there; undefined -> seconds_left=0 throughout.
